seg_scan_decoder: RTL and testbench



---
 rtl/seg_scan_decoder.sv | 178 +++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed seven-segment bus: it samples anodes and
// segments, captures each settled dwell and publishes complete frames atomically.
module seg_scan_decoder #(
  parameter int DIGITS         = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DIGITS-1:0]   an,
  input  logic [7:0]          sig_c,
  output logic [4*DIGITS-1:0] digit_val,
  output logic [DIGITS-1:0]   digit_blank,
  output logic [DIGITS-1:0]   digit_dp,
  output logic                frame_valid,
  output logic                seg_err,
  output logic                an_err,
  output logic                stall
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] STABLE_MAX  = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [DIGITS-1:0]   an_q, an_p, an_act;
  logic [7:0]          sig_q, sig_p;
  logic [CW-1:0]       stable_cnt, stable_nxt;
  logic [TW-1:0]       idle_cnt;
  logic                dwell_done, multi_seen;
  logic [4*DIGITS-1:0] sh_val, sh_val_nxt;
  logic [DIGITS-1:0]   sh_blank, sh_blank_nxt, sh_dp, sh_dp_nxt;
  logic [DIGITS-1:0]   seen, seen_nxt;
  logic [IW-1:0]       sel_idx;
  logic                sel_one, sel_multi, same, capture;
  logic                glyph_ok, glyph_blank, frame_done, timed_out;
  logic [3:0]          glyph_val;

  // Result is {ok, blank, value}; segments are active low.
  function automatic logic [5:0] decode_glyph(input logic [6:0] g);
    logic [5:0] r;
    r = 6'b000000;
    case (g)
      7'h40: r = {2'b10, 4'h0};
      7'h79: r = {2'b10, 4'h1};
      7'h24: r = {2'b10, 4'h2};
      7'h30: r = {2'b10, 4'h3};
      7'h19: r = {2'b10, 4'h4};
      7'h12: r = {2'b10, 4'h5};
      7'h02: r = {2'b10, 4'h6};
      7'h78: r = {2'b10, 4'h7};
      7'h00: r = {2'b10, 4'h8};
      7'h10: r = {2'b10, 4'h9};
      7'h08: r = {2'b10, 4'hA};
      7'h03: r = {2'b10, 4'hB};
      7'h46: r = {2'b10, 4'hC};
      7'h21: r = {2'b10, 4'hD};
      7'h06: r = {2'b10, 4'hE};
      7'h0E: r = {2'b10, 4'hF};
      7'h7F: r = {2'b11, 4'h0};
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  assign an_act = ~an_q;

  always_comb begin
    sel_idx      = '0;
    sel_one      = 1'b0;
    sel_multi    = 1'b0;
    same         = 1'b0;
    stable_nxt   = '0;
    capture      = 1'b0;
    glyph_ok     = 1'b0;
    glyph_blank  = 1'b0;
    glyph_val    = 4'h0;
    seg_err      = 1'b0;
    an_err       = 1'b0;
    sh_val_nxt   = sh_val;
    sh_blank_nxt = sh_blank;
    sh_dp_nxt    = sh_dp;
    seen_nxt     = seen;
    frame_done   = 1'b0;
    timed_out    = 1'b0;

    // A select is valid when exactly one anode is pulled low.
    sel_one   = (an_act != '0) && ((an_act & (an_act - DIGITS'(1))) == '0);
    sel_multi = (an_act != '0) && !sel_one;
    for (int i = 0; i < DIGITS; i++) begin
      if (an_act[i]) sel_idx = IW'(i);
    end

    same = (an_q == an_p) && (sig_q == sig_p);
    if (sel_one && same) begin
      stable_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 1'b1;
    end

    // One capture per dwell: dwell_done blocks the saturated counter from refiring.
    capture = sel_one && same && (stable_nxt == STABLE_MAX) && !dwell_done;
    {glyph_ok, glyph_blank, glyph_val} = decode_glyph(sig_q[6:0]);
    seg_err = capture && !glyph_ok;
    an_err  = sel_multi && !multi_seen;

    if (capture) begin
      seen_nxt = seen | an_act;
      if (glyph_ok) begin
        sh_val_nxt[4*sel_idx +: 4] = glyph_val;
        sh_blank_nxt[sel_idx]      = glyph_blank;
        sh_dp_nxt[sel_idx]         = ~sig_q[7];
      end
    end

    frame_done = capture && (&seen_nxt);
    timed_out  = !capture && (idle_cnt == TIMEOUT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q        <= '1;
      an_p        <= '1;
      sig_q       <= '1;
      sig_p       <= '1;
      stable_cnt  <= '0;
      dwell_done  <= 1'b0;
      multi_seen  <= 1'b0;
      idle_cnt    <= '0;
      sh_val      <= '0;
      sh_blank    <= '0;
      sh_dp       <= '0;
      seen        <= '0;
      digit_val   <= '0;
      digit_blank <= '1;
      digit_dp    <= '0;
      frame_valid <= 1'b0;
      stall       <= 1'b0;
    end else begin
      an_q       <= an;
      sig_q      <= sig_c;
      an_p       <= an_q;
      sig_p      <= sig_q;
      stable_cnt <= stable_nxt;
      multi_seen <= sel_multi;
      sh_val     <= sh_val_nxt;
      sh_blank   <= sh_blank_nxt;
      sh_dp      <= sh_dp_nxt;

      if (capture) begin
        dwell_done <= 1'b1;
      end else if (an_q != an_p) begin
        dwell_done <= 1'b0;
      end

      if (capture) begin
        idle_cnt <= '0;
      end else if (idle_cnt != TIMEOUT_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end

      frame_valid <= frame_done;
      if (frame_done) begin
        digit_val   <= sh_val_nxt;
        digit_blank <= sh_blank_nxt;
        digit_dp    <= sh_dp_nxt;
        seen        <= '0;
        stall       <= 1'b0;
      end else if (timed_out) begin
        // Outputs keep the last published frame; only the partial frame is dropped.
        seen  <= '0;
        stall <= 1'b1;
      end else begin
        seen <= seen_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: table-driven frame scans, hand-written corner
// sequences, and a randomized dwell stream checked against a dwell-level model.
`timescale 1ns/1ps
module tb_seg_scan_decoder;

  localparam int DIGITS  = 8;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 200;
  localparam logic [7:0] IDLE_AN = 8'hFF;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  an;
  logic [7:0]  sig_c;
  logic [31:0] digit_val;
  logic [7:0]  digit_blank;
  logic [7:0]  digit_dp;
  logic        frame_valid, seg_err, an_err, stall;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .sig_c(sig_c),
    .digit_val(digit_val), .digit_blank(digit_blank), .digit_dp(digit_dp),
    .frame_valid(frame_valid), .seg_err(seg_err), .an_err(an_err), .stall(stall)
  );

  typedef struct packed {
    logic [63:0] glyphs;     // sig_c for digit d at [8d+7:8d]
    logic [7:0]  len;
    logic [31:0] exp_val;
    logic [7:0]  exp_blank;
    logic [7:0]  exp_dp;
    logic [7:0]  exp_frames;
  } vec_t;

  vec_t vecs [4];

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- monitor ----------------
  int          fv_cnt = 0;
  int          se_cnt = 0;
  int          ae_cnt = 0;
  logic [47:0] got_q[$];
  logic [47:0] exp_q[$];

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt <= fv_cnt + 1;
      got_q.push_back({digit_val, digit_blank, digit_dp});
    end
    if (seg_err) se_cnt <= se_cnt + 1;
    if (an_err)  ae_cnt <= ae_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [7:0] an_of(input int d);
    logic [7:0] m;
    m = 8'h01 << d;
    return ~m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; holds the bus for exactly len sampling edges.
  task automatic dwell(input logic [7:0] a, input logic [7:0] s, input int len);
    an = a;
    sig_c = s;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic scan(input logic [63:0] g, input int first, input int last, input int len);
    for (int d = first; d <= last; d++) dwell(an_of(d), g[8*d +: 8], len);
  endtask

  task automatic dwell_watch(input logic [7:0] a, input logic [7:0] s, input int len,
                             output int se_at, output int fv_at);
    se_at = -1;
    fv_at = -1;
    an = a;
    sig_c = s;
    for (int i = 1; i <= len; i++) begin
      @(posedge clk);
      #1;
      if (seg_err && se_at < 0) se_at = i;
      if (frame_valid && fv_at < 0) fv_at = i;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_val"},   digit_val, 32'h0);
    check({tag, "_blank"}, digit_blank, 8'hFF);
    check({tag, "_dp"},    digit_dp, 8'h00);
    check({tag, "_fv"},    frame_valid, 1'b0);
    check({tag, "_serr"},  seg_err, 1'b0);
    check({tag, "_aerr"},  an_err, 1'b0);
    check({tag, "_stall"}, stall, 1'b0);
  endtask

  // ---------------- reference model (dwell level) ----------------
  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] m_val   [DIGITS];
  logic       m_blank [DIGITS];
  logic       m_dp    [DIGITS];
  logic       m_seen  [DIGITS];
  int         m_se;
  int         m_ae;

  task automatic model_capture(input int d, input logic [7:0] g);
    logic ok, blank, all_seen;
    logic [3:0] v;
    logic [47:0] f;
    ok = 1'b0;
    blank = 1'b0;
    v = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (glyph_tab[i] == g[6:0]) begin
        ok = 1'b1;
        v = 4'(i);
      end
    end
    if (g[6:0] == 7'h7F) begin
      ok = 1'b1;
      blank = 1'b1;
    end
    if (ok) begin
      m_val[d] = v;
      m_blank[d] = blank;
      m_dp[d] = ~g[7];
    end else begin
      m_se++;
    end
    m_seen[d] = 1'b1;
    all_seen = 1'b1;
    for (int i = 0; i < DIGITS; i++) all_seen = all_seen & m_seen[i];
    if (all_seen) begin
      f = '0;
      for (int i = 0; i < DIGITS; i++) begin
        f[16 + 4*i +: 4] = m_val[i];
        f[8 + i] = m_blank[i];
        f[i] = m_dp[i];
        m_seen[i] = 1'b0;
      end
      exp_q.push_back(f);
    end
  endtask

  // ---------------- test ----------------
  int f0, s0, a0, base, se_at, fv_at, since_cap, kind, len, d, x, y;
  logic [7:0] g, a;

  initial begin
    vecs[0] = '{glyphs: 64'h80F8_8292_99B0_A4F9, len: 8'd10, exp_val: 32'h8765_4321,
                exp_blank: 8'h00, exp_dp: 8'h00, exp_frames: 8'd1};
    vecs[1] = '{glyphs: 64'hA1C6_1283_FF88_90C0, len: 8'd6, exp_val: 32'hDC5B_0A90,
                exp_blank: 8'h08, exp_dp: 8'h20, exp_frames: 8'd1};
    vecs[2] = '{glyphs: 64'hA4B0_7F82_F80E_8E86, len: 8'd4, exp_val: 32'h2306_7FFE,
                exp_blank: 8'h20, exp_dp: 8'h24, exp_frames: 8'd1};
    vecs[3] = '{glyphs: 64'h80F8_8292_99B0_A4F9, len: 8'd3, exp_val: 32'h2306_7FFE,
                exp_blank: 8'h20, exp_dp: 8'h24, exp_frames: 8'd0};

    rst_n = 1'b0;
    an = IDLE_AN;
    sig_c = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table: full scans, including the exact-threshold and too-short dwells.
    for (int i = 0; i < 4; i++) begin
      f0 = fv_cnt;
      scan(vecs[i].glyphs, 0, DIGITS - 1, int'(vecs[i].len));
      dwell(IDLE_AN, 8'hFF, 8);
      check($sformatf("vec%0d_frames", i), fv_cnt - f0, vecs[i].exp_frames);
      check($sformatf("vec%0d_val", i), digit_val, vecs[i].exp_val);
      check($sformatf("vec%0d_blank", i), digit_blank, vecs[i].exp_blank);
      check($sformatf("vec%0d_dp", i), digit_dp, vecs[i].exp_dp);
    end

    // Timeout after the short-dwell scan; the next frame clears stall.
    check("stall_before_timeout", stall, 1'b0);
    dwell(IDLE_AN, 8'hFF, TIMEOUT + 5);
    check("stall_after_timeout", stall, 1'b1);
    check("timeout_keeps_val", digit_val, 32'h2306_7FFE);
    f0 = fv_cnt;
    scan(vecs[0].glyphs, 0, DIGITS - 1, 8);
    dwell(IDLE_AN, 8'hFF, 8);
    check("stall_clear_frames", fv_cnt - f0, 1);
    check("stall_cleared", stall, 1'b0);
    check("stall_clear_val", digit_val, 32'h8765_4321);

    // Undecodable glyph on the completing capture of digit 2.
    f0 = fv_cnt;
    s0 = se_cnt;
    scan(vecs[1].glyphs, 0, 1, 6);
    scan(vecs[1].glyphs, 3, 7, 6);
    dwell_watch(an_of(2), 8'h55, 10, se_at, fv_at);
    dwell(IDLE_AN, 8'hFF, 8);
    check("segerr_count", se_cnt - s0, 1);
    check("segerr_frames", fv_cnt - f0, 1);
    check("segerr_latency", se_at, STABLE);
    check("segerr_fv_latency", fv_at, STABLE + 1);
    check("segerr_val", digit_val, 32'hDC5B_0390);
    check("segerr_blank", digit_blank, 8'h08);
    check("segerr_dp", digit_dp, 8'h20);

    // Multi-select held mid-scan.
    f0 = fv_cnt;
    a0 = ae_cnt;
    scan(vecs[0].glyphs, 0, 3, 6);
    dwell(8'hFC, 8'h80, 20);
    check("multi_no_frame_mid", fv_cnt - f0, 0);
    check("multi_err_mid", ae_cnt - a0, 1);
    scan(vecs[0].glyphs, 4, 7, 6);
    dwell(IDLE_AN, 8'hFF, 8);
    check("multi_err_count", ae_cnt - a0, 1);
    check("multi_frames", fv_cnt - f0, 1);
    check("multi_val", digit_val, 32'h8765_4321);
    check("multi_blank", digit_blank, 8'h00);

    // Reset mid-frame discards the partial frame.
    scan(vecs[1].glyphs, 0, 4, 6);
    an = IDLE_AN;
    sig_c = 8'hFF;
    rst_n = 1'b0;
    #2;
    check_reset_values("midrst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    f0 = fv_cnt;
    scan(vecs[2].glyphs, 5, 7, 6);
    dwell(IDLE_AN, 8'hFF, 8);
    check("postrst_partial", fv_cnt - f0, 0);
    scan(vecs[2].glyphs, 0, 4, 6);
    dwell(IDLE_AN, 8'hFF, 8);
    check("postrst_frames", fv_cnt - f0, 1);
    check("postrst_val", digit_val, 32'h2306_7FFE);
    check("postrst_blank", digit_blank, 8'h20);
    check("postrst_dp", digit_dp, 8'h24);

    // Random dwell stream; model shadow starts from the last published frame.
    for (int i = 0; i < DIGITS; i++) begin
      g = vecs[2].glyphs[8*i +: 8];
      m_val[i] = vecs[2].exp_val[4*i +: 4];
      m_blank[i] = vecs[2].exp_blank[i];
      m_dp[i] = ~g[7];
      m_seen[i] = 1'b0;
    end
    m_se = 0;
    m_ae = 0;
    base = got_q.size();
    s0 = se_cnt;
    a0 = ae_cnt;
    since_cap = 0;
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 99));
      len = int'($urandom_range(1, 8));
      if (since_cap > 100) begin
        kind = 0;
        len = STABLE + int'($urandom_range(0, 4));
      end
      if (kind < 85) begin
        d = int'($urandom_range(0, DIGITS - 1));
        x = int'($urandom_range(0, 99));
        if (x < 75) g = {1'($urandom_range(0, 1)), glyph_tab[$urandom_range(0, 15)]};
        else if (x < 85) g = {1'($urandom_range(0, 1)), 7'h7F};
        else g = 8'($urandom_range(0, 255));
        dwell(an_of(d), g, len);
        if (len >= STABLE) begin
          model_capture(d, g);
          since_cap = 0;
        end else begin
          since_cap += len;
        end
      end else if (kind < 92) begin
        x = int'($urandom_range(0, DIGITS - 1));
        y = (x + 1 + int'($urandom_range(0, DIGITS - 2))) % DIGITS;
        a = an_of(x) & an_of(y);
        dwell(a, 8'($urandom_range(0, 255)), len);
        m_ae++;
        since_cap += len;
      end else begin
        dwell(IDLE_AN, 8'($urandom_range(0, 255)), len);
        since_cap += len;
      end
      dwell(IDLE_AN, 8'hFF, 1);
      since_cap += 1;
    end
    dwell(IDLE_AN, 8'hFF, 10);

    check("rand_frame_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      check($sformatf("rand_frame%0d", i), got_q[base + i], exp_q[i]);
    end
    check("rand_seg_err", se_cnt - s0, m_se);
    check("rand_an_err", ae_cnt - a0, m_ae);
    check("rand_stall", stall, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
